// File: rtl/montgomery_seq.sv
// Sequencer for Montgomery modular multiply/exponentiation that drives a
// shared external Montgomery multiplier; it does operand muxing and bit counting only.
module montgomery_seq #(
    parameter int NBITS      = 2048,
    parameter int EBITS      = 64,
    parameter int CONST_TIME = 0,
    localparam int MW        = $clog2(NBITS) + 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_p,
    input  logic             mode,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic [EBITS-1:0] e,
    input  logic [NBITS-1:0] m,
    input  logic [MW-1:0]    m_size,
    input  logic [NBITS-1:0] r_red,
    output logic [NBITS-1:0] y,
    output logic             done_irq_p,
    output logic             busy,
    output logic             eng_enable_p,
    output logic [NBITS-1:0] eng_a,
    output logic [NBITS-1:0] eng_b,
    output logic [NBITS-1:0] eng_m,
    output logic [MW-1:0]    eng_m_size,
    input  logic [NBITS-1:0] eng_y,
    input  logic             eng_done_irq_p
);

    localparam int IW = (EBITS > 1) ? $clog2(EBITS) : 1;
    localparam logic [NBITS-1:0] ONE_V   = NBITS'(1);
    localparam logic [IW-1:0]    TOP_IDX = IW'(EBITS - 1);
    localparam logic [IW-1:0]    IDX_ONE = IW'(1);
    localparam logic             CT      = (CONST_TIME != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_CONV_A, S_CONV_B, S_ONE, S_MUL, S_SQR, S_EMUL, S_FROM
    } state_e;

    state_e            state_q, state_d;
    logic              wait_q, wait_d;
    logic              mode_q, mode_d;
    logic [NBITS-1:0]  b_q, b_d;
    logic [EBITS-1:0]  e_q, e_d;
    logic [NBITS-1:0]  r_red_q, r_red_d;
    logic [NBITS-1:0]  am_q, am_d;
    logic [NBITS-1:0]  acc_q, acc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NBITS-1:0]  y_q, y_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              eng_en_q, eng_en_d;
    logic [NBITS-1:0]  eng_a_q, eng_a_d;
    logic [NBITS-1:0]  eng_b_q, eng_b_d;
    logic [NBITS-1:0]  eng_m_q, eng_m_d;
    logic [MW-1:0]     eng_ms_q, eng_ms_d;
    logic              bit_set_s;
    logic              last_bit_s;
    logic [NBITS-1:0]  emul_acc_s;

    // Next-state, operand selection and output update for the sequencer.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        mode_d   = mode_q;
        b_d      = b_q;
        e_d      = e_q;
        r_red_d  = r_red_q;
        am_d     = am_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        y_d      = y_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        eng_en_d = 1'b0;
        eng_a_d  = eng_a_q;
        eng_b_d  = eng_b_q;
        eng_m_d  = eng_m_q;
        eng_ms_d = eng_ms_q;
        bit_set_s  = e_q[idx_q];
        last_bit_s = (idx_q == {IW{1'b0}});
        // A clear-bit EMUL (constant-time mode) leaves the accumulator untouched.
        emul_acc_s = bit_set_s ? eng_y : acc_q;

        case (state_q)
            S_IDLE: begin
                if (enable_p) begin
                    mode_d   = mode;
                    b_d      = b;
                    e_d      = e;
                    r_red_d  = r_red;
                    eng_m_d  = m;
                    eng_ms_d = m_size;
                    idx_d    = TOP_IDX;
                    busy_d   = 1'b1;
                    state_d  = S_CONV_A;
                    wait_d   = 1'b0;
                    eng_en_d = 1'b1;
                    eng_a_d  = a;
                    eng_b_d  = r_red;
                end else begin
                    busy_d = 1'b0;
                end
            end
            default: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else if (eng_done_irq_p) begin
                    wait_d   = 1'b0;
                    eng_en_d = 1'b1;
                    case (state_q)
                        S_CONV_A: begin
                            am_d = eng_y;
                            if (mode_q) begin
                                state_d = S_ONE;
                                eng_a_d = r_red_q;
                                eng_b_d = ONE_V;
                            end else begin
                                state_d = S_CONV_B;
                                eng_a_d = b_q;
                                eng_b_d = r_red_q;
                            end
                        end
                        S_CONV_B: begin
                            state_d = S_MUL;
                            eng_a_d = am_q;
                            eng_b_d = eng_y;
                        end
                        S_MUL: begin
                            state_d = S_FROM;
                            eng_a_d = eng_y;
                            eng_b_d = ONE_V;
                        end
                        S_ONE: begin
                            acc_d   = eng_y;
                            state_d = S_SQR;
                            eng_a_d = eng_y;
                            eng_b_d = eng_y;
                        end
                        S_SQR: begin
                            acc_d = eng_y;
                            if (bit_set_s || CT) begin
                                state_d = S_EMUL;
                                eng_a_d = eng_y;
                                eng_b_d = am_q;
                            end else if (last_bit_s) begin
                                state_d = S_FROM;
                                eng_a_d = eng_y;
                                eng_b_d = ONE_V;
                            end else begin
                                idx_d   = idx_q - IDX_ONE;
                                state_d = S_SQR;
                                eng_a_d = eng_y;
                                eng_b_d = eng_y;
                            end
                        end
                        S_EMUL: begin
                            acc_d = emul_acc_s;
                            if (last_bit_s) begin
                                state_d = S_FROM;
                                eng_a_d = emul_acc_s;
                                eng_b_d = ONE_V;
                            end else begin
                                idx_d   = idx_q - IDX_ONE;
                                state_d = S_SQR;
                                eng_a_d = emul_acc_s;
                                eng_b_d = emul_acc_s;
                            end
                        end
                        S_FROM: begin
                            state_d  = S_IDLE;
                            eng_en_d = 1'b0;
                            y_d      = eng_y;
                            done_d   = 1'b1;
                        end
                        default: begin
                            state_d  = S_IDLE;
                            eng_en_d = 1'b0;
                        end
                    endcase
                end else begin
                    wait_d = 1'b1;
                end
            end
        endcase
    end

    // State and output registers; reset returns to an idle, all-zero interface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wait_q   <= 1'b0;
            mode_q   <= 1'b0;
            b_q      <= {NBITS{1'b0}};
            e_q      <= {EBITS{1'b0}};
            r_red_q  <= {NBITS{1'b0}};
            am_q     <= {NBITS{1'b0}};
            acc_q    <= {NBITS{1'b0}};
            idx_q    <= {IW{1'b0}};
            y_q      <= {NBITS{1'b0}};
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            eng_en_q <= 1'b0;
            eng_a_q  <= {NBITS{1'b0}};
            eng_b_q  <= {NBITS{1'b0}};
            eng_m_q  <= {NBITS{1'b0}};
            eng_ms_q <= {MW{1'b0}};
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            mode_q   <= mode_d;
            b_q      <= b_d;
            e_q      <= e_d;
            r_red_q  <= r_red_d;
            am_q     <= am_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            y_q      <= y_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            eng_en_q <= eng_en_d;
            eng_a_q  <= eng_a_d;
            eng_b_q  <= eng_b_d;
            eng_m_q  <= eng_m_d;
            eng_ms_q <= eng_ms_d;
        end
    end

    assign y            = y_q;
    assign done_irq_p   = done_q;
    assign busy         = busy_q;
    assign eng_enable_p = eng_en_q;
    assign eng_a        = eng_a_q;
    assign eng_b        = eng_b_q;
    assign eng_m        = eng_m_q;
    assign eng_m_size   = eng_ms_q;

endmodule

// File: tb/tb_montgomery_seq.sv
// Bench for montgomery_seq: two instances (CONST_TIME 0 and 1), each with a
// 3-cycle behavioural Montgomery engine, checked against plain modular arithmetic.
module tb_montgomery_seq;

    localparam int NB = 16;
    localparam int EB = 4;
    localparam int MW = $clog2(NB) + 3;

    typedef logic [NB-1:0] yarr_t [2];
    typedef int iarr_t [2];

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          enable_p, mode;
    logic [NB-1:0] a, b, m, r_red;
    logic [EB-1:0] e;
    logic [MW-1:0] m_size;

    logic [NB-1:0] y [2];
    logic          done_irq_p [2];
    logic          busy [2];
    logic          eng_enable_p [2];
    logic [NB-1:0] eng_a [2];
    logic [NB-1:0] eng_b [2];
    logic [NB-1:0] eng_m [2];
    logic [MW-1:0] eng_m_size [2];
    logic          eng_done_obs [2];

    int checks = 0;
    int errors = 0;

    function automatic logic [NB-1:0] mont(input logic [NB-1:0] xa, input logic [NB-1:0] xb,
                                           input logic [NB-1:0] xm, input logic [MW-1:0] xs);
        longint p, r;
        if (xm == '0) return '0;
        p = (longint'(xa) * longint'(xb)) % longint'(xm);
        r = (longint'(1) << xs) % longint'(xm);
        for (int i = 0; i < int'(xm); i++)
            if ((longint'(i) * r) % longint'(xm) == p) return NB'(i);
        return '0;
    endfunction

    function automatic logic [NB-1:0] ref_pow(input longint base, input int ex, input longint md);
        longint r;
        r = 1 % md;
        for (int i = 0; i < ex; i++) r = (r * base) % md;
        return NB'(r);
    endfunction

    function automatic int exp_ops(input int k, input logic md, input logic [EB-1:0] ev);
        if (!md) return 4;
        return 3 + EB + ((k == 1) ? EB : $countones(ev));
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic          eng_done_l = 1'b0;
        logic [NB-1:0] eng_y_l = '0;
        logic [NB-1:0] res = '0;
        int            cnt = 0;

        montgomery_seq #(.NBITS(NB), .EBITS(EB), .CONST_TIME(k)) dut (
            .clk(clk), .rst_n(rst_n), .enable_p(enable_p), .mode(mode),
            .a(a), .b(b), .e(e), .m(m), .m_size(m_size), .r_red(r_red),
            .y(y[k]), .done_irq_p(done_irq_p[k]), .busy(busy[k]),
            .eng_enable_p(eng_enable_p[k]), .eng_a(eng_a[k]), .eng_b(eng_b[k]),
            .eng_m(eng_m[k]), .eng_m_size(eng_m_size[k]),
            .eng_y(eng_y_l), .eng_done_irq_p(eng_done_l)
        );

        always @(posedge clk) begin
            eng_done_l <= 1'b0;
            if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    eng_done_l <= 1'b1;
                    eng_y_l    <= res;
                end
            end
            if (eng_enable_p[k]) begin
                cnt <= 3;
                res <= mont(eng_a[k], eng_b[k], eng_m[k], eng_m_size[k]);
            end
        end
        assign eng_done_obs[k] = eng_done_l;
    end

    task automatic set_modulus(input int mv, input int ms);
        m      = NB'(mv);
        m_size = MW'(ms);
        r_red  = NB'((longint'(1) << (2 * ms)) % longint'(mv));
    endtask

    // Starts one operation on both instances and observes them until both complete.
    task automatic run_op(input logic md, input logic [NB-1:0] av, input logic [NB-1:0] bv,
                          input logic [EB-1:0] ev, input int reen_at,
                          output yarr_t ys, output iarr_t ops,
                          output bit first_ok, output bit lat_ok, output bit busy_ok,
                          output bit timed_out);
        int  last_ed [2];
        bit  got [2];
        bit  post [2];
        int  cy;
        mode = md; a = av; b = bv; e = ev;
        first_ok = 1'b1; lat_ok = 1'b1; busy_ok = 1'b1; timed_out = 1'b0;
        for (int k = 0; k < 2; k++) begin
            got[k] = 1'b0; post[k] = 1'b0; last_ed[k] = -10; ops[k] = 0; ys[k] = '0;
        end
        if (eng_enable_p[0] || eng_enable_p[1]) first_ok = 1'b0;
        enable_p = 1'b1;
        @(negedge clk);
        enable_p = 1'b0;
        cy = 1;
        while (!(post[0] && post[1])) begin
            if (cy == 1 && !(eng_enable_p[0] && eng_enable_p[1] && busy[0] && busy[1]))
                first_ok = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (eng_enable_p[k]) ops[k]++;
                if (eng_done_obs[k]) last_ed[k] = cy;
                if (got[k] && !post[k]) begin
                    post[k] = 1'b1;
                    if (busy[k] || done_irq_p[k]) busy_ok = 1'b0;
                end else if (done_irq_p[k] && !got[k]) begin
                    got[k] = 1'b1;
                    ys[k]  = y[k];
                    if (last_ed[k] != cy - 1) lat_ok = 1'b0;
                    if (!busy[k]) busy_ok = 1'b0;
                end else if (!got[k] && !busy[k]) begin
                    busy_ok = 1'b0;
                end
            end
            if (cy == reen_at) begin
                enable_p = 1'b1; mode = ~md; a = ~av; b = ~bv; e = ~ev;
            end else begin
                enable_p = 1'b0;
            end
            if (cy >= 600) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            cy++;
        end
        enable_p = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (y[k] !== '0) begin errors++; $display("FAIL reset_y[%0d]: got %0d expected 0", k, y[k]); end
            checks++; if (done_irq_p[k] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b expected 0", k, done_irq_p[k]); end
            checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy[k]); end
            checks++; if (eng_enable_p[k] !== 1'b0) begin errors++; $display("FAIL reset_eng_en[%0d]: got %b expected 0", k, eng_enable_p[k]); end
            checks++; if (eng_a[k] !== '0 || eng_b[k] !== '0) begin errors++; $display("FAIL reset_eng_ab[%0d]: got %0d/%0d expected 0/0", k, eng_a[k], eng_b[k]); end
            checks++; if (eng_m[k] !== '0 || eng_m_size[k] !== '0) begin errors++; $display("FAIL reset_eng_m[%0d]: got %0d/%0d expected 0/0", k, eng_m[k], eng_m_size[k]); end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (busy[k] !== 1'b0 || done_irq_p[k] !== 1'b0) begin errors++; $display("FAIL reset_idle[%0d]: busy %b done %b expected 0 0", k, busy[k], done_irq_p[k]); end
        end
    endtask

    task automatic test_mul();
        yarr_t ys; iarr_t ops; bit f, l, bz, to;
        set_modulus(13, 4);
        run_op(1'b0, 16'd5, 16'd7, 4'd0, -1, ys, ops, f, l, bz, to);
        checks++; if (to) begin errors++; $display("FAIL mul_timeout: got timeout expected completion"); end
        for (int k = 0; k < 2; k++) begin
            checks++; if (ys[k] !== 16'd9) begin errors++; $display("FAIL mul_y[%0d]: got %0d expected 9", k, ys[k]); end
            checks++; if (ops[k] !== 4) begin errors++; $display("FAIL mul_ops[%0d]: got %0d expected 4", k, ops[k]); end
        end
        checks++; if (!f) begin errors++; $display("FAIL mul_first_issue: got late/missing expected 1 cycle after enable"); end
        checks++; if (!l) begin errors++; $display("FAIL mul_done_latency: got wrong expected 1 cycle after last engine done"); end
        checks++; if (!bz) begin errors++; $display("FAIL mul_busy: got wrong busy window expected high through done"); end
    endtask

    task automatic test_exp();
        yarr_t ys; iarr_t ops; bit f, l, bz, to;
        set_modulus(13, 4);
        run_op(1'b1, 16'd2, 16'd0, 4'd10, -1, ys, ops, f, l, bz, to);
        checks++; if (to) begin errors++; $display("FAIL exp_timeout: got timeout expected completion"); end
        for (int k = 0; k < 2; k++) begin
            checks++; if (ys[k] !== 16'd10) begin errors++; $display("FAIL exp_y[%0d]: got %0d expected 10", k, ys[k]); end
            checks++; if (ops[k] !== exp_ops(k, 1'b1, 4'd10)) begin errors++; $display("FAIL exp_ops[%0d]: got %0d expected %0d", k, ops[k], exp_ops(k, 1'b1, 4'd10)); end
        end
        checks++; if (!(f && l && bz)) begin errors++; $display("FAIL exp_timing: got first %b lat %b busy %b expected 1 1 1", f, l, bz); end
    endtask

    task automatic test_exp_zero();
        yarr_t ys; iarr_t ops; bit f, l, bz, to;
        set_modulus(13, 4);
        run_op(1'b1, 16'd6, 16'd0, 4'd0, -1, ys, ops, f, l, bz, to);
        checks++; if (to) begin errors++; $display("FAIL expz_timeout: got timeout expected completion"); end
        for (int k = 0; k < 2; k++) begin
            checks++; if (ys[k] !== 16'd1) begin errors++; $display("FAIL expz_y[%0d]: got %0d expected 1", k, ys[k]); end
            checks++; if (ops[k] !== exp_ops(k, 1'b1, 4'd0)) begin errors++; $display("FAIL expz_ops[%0d]: got %0d expected %0d", k, ops[k], exp_ops(k, 1'b1, 4'd0)); end
        end
    endtask

    task automatic test_reenable();
        yarr_t ys; iarr_t ops; bit f, l, bz, to;
        set_modulus(13, 4);
        run_op(1'b1, 16'd2, 16'd0, 4'd10, 10, ys, ops, f, l, bz, to);
        checks++; if (to) begin errors++; $display("FAIL reen_timeout: got timeout expected completion"); end
        for (int k = 0; k < 2; k++) begin
            checks++; if (ys[k] !== 16'd10) begin errors++; $display("FAIL reen_y[%0d]: got %0d expected 10", k, ys[k]); end
            checks++; if (ops[k] !== exp_ops(k, 1'b1, 4'd10)) begin errors++; $display("FAIL reen_ops[%0d]: got %0d expected %0d", k, ops[k], exp_ops(k, 1'b1, 4'd10)); end
        end
        checks++; if (!bz) begin errors++; $display("FAIL reen_busy: got wrong busy window expected high through done"); end
    endtask

    task automatic test_midreset();
        int n; bit saw_late, bad_done, bad_out;
        yarr_t ys; iarr_t ops; bit f, l, bz, to;
        set_modulus(13, 4);
        mode = 1'b1; a = 16'd2; b = 16'd0; e = 4'd10;
        enable_p = 1'b1;
        @(negedge clk);
        enable_p = 1'b0;
        n = eng_enable_p[0] ? 1 : 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (eng_enable_p[0]) n++;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL midrst_reach_sqr: got %0d issues expected 3", n); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (y[k] !== '0 || busy[k] !== 1'b0 || done_irq_p[k] !== 1'b0 || eng_enable_p[k] !== 1'b0 ||
                eng_a[k] !== '0 || eng_b[k] !== '0 || eng_m[k] !== '0 || eng_m_size[k] !== '0) begin
                errors++;
                $display("FAIL midrst_outputs[%0d]: got y %0d busy %b eng_a %0d eng_m %0d expected all 0", k, y[k], busy[k], eng_a[k], eng_m[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_late = 1'b0; bad_done = 1'b0; bad_out = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (eng_done_obs[0]) saw_late = 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (done_irq_p[k]) bad_done = 1'b1;
                if (y[k] !== '0 || busy[k] !== 1'b0 || eng_enable_p[k] !== 1'b0 || eng_a[k] !== '0) bad_out = 1'b1;
            end
        end
        checks++; if (!saw_late) begin errors++; $display("FAIL midrst_late_done: got none expected a late engine done"); end
        checks++; if (bad_done) begin errors++; $display("FAIL midrst_no_done: got done_irq_p expected none"); end
        checks++; if (bad_out) begin errors++; $display("FAIL midrst_idle: got nonzero outputs expected 0 after late done"); end
        run_op(1'b0, 16'd5, 16'd7, 4'd0, -1, ys, ops, f, l, bz, to);
        for (int k = 0; k < 2; k++) begin
            checks++; if (ys[k] !== 16'd9 || to) begin errors++; $display("FAIL midrst_mul_y[%0d]: got %0d expected 9", k, ys[k]); end
        end
    endtask

    task automatic test_random();
        yarr_t ys; iarr_t ops; bit f, l, bz, to;
        int mv; logic md; logic [NB-1:0] av, bv, ye; logic [EB-1:0] ev;
        for (int it = 0; it < 8; it++) begin
            mv = 2 * int'($urandom_range(1, 15)) + 1;
            set_modulus(mv, 5);
            md = 1'($urandom_range(0, 1));
            av = NB'($urandom_range(0, mv - 1));
            bv = NB'($urandom_range(0, mv - 1));
            ev = EB'($urandom_range(0, 15));
            ye = md ? ref_pow(longint'(av), int'(ev), longint'(mv))
                    : NB'((longint'(av) * longint'(bv)) % longint'(mv));
            run_op(md, av, bv, ev, -1, ys, ops, f, l, bz, to);
            checks++; if (to) begin errors++; $display("FAIL rand_timeout it%0d: got timeout expected completion", it); end
            for (int k = 0; k < 2; k++) begin
                checks++; if (ys[k] !== ye) begin errors++; $display("FAIL rand_y[%0d] it%0d m=%0d mode=%b a=%0d b=%0d e=%0d: got %0d expected %0d", k, it, mv, md, av, bv, ev, ys[k], ye); end
                checks++; if (ops[k] !== exp_ops(k, md, ev)) begin errors++; $display("FAIL rand_ops[%0d] it%0d: got %0d expected %0d", k, it, ops[k], exp_ops(k, md, ev)); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; enable_p = 1'b0; mode = 1'b0;
        a = '0; b = '0; e = '0; m = '0; m_size = '0; r_red = '0;
        test_reset();
        test_mul();
        test_exp();
        test_exp_zero();
        test_reenable();
        test_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/montgomery_seq.md
MONTGOMERY_SEQ -- requirements
Module: montgomery_seq

Parameters
REQ-001 NBITS, 2048, operand, modulus and result width.
REQ-002 EBITS, 64, exponent width.
REQ-003 CONST_TIME, 0, when 1, every exponent bit issues a multiply; the result of a clear-bit multiply is discarded.

Interface
REQ-004 clk  in  1  sole clock; all logic is rising-edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 enable_p  in  1  single-cycle start pulse.
REQ-007 mode  in  1  0 = MUL (a*b mod m), 1 = EXP (a^e mod m).
REQ-008 a, b  in  NBITS  operands; b is unused in EXP.
REQ-009 e  in  EBITS  exponent; unused in MUL.
REQ-010 m  in  NBITS  odd modulus.
REQ-011 m_size  in  $clog2(NBITS)+3  modulus bit length; R = 2^m_size.
REQ-012 r_red  in  NBITS  R^2 mod m.
REQ-013 y  out  NBITS  result.
REQ-014 done_irq_p  out  1  single-cycle completion pulse.
REQ-015 busy  out  1  high from the cycle after an accepted enable_p through the done_irq_p cycle.
REQ-016 eng_enable_p  out  1  start pulse to the shared external Montgomery multiplier.
REQ-017 eng_a, eng_b  out  NBITS  engine operands.
REQ-018 eng_m  out  NBITS  latched m.
REQ-019 eng_m_size  out  $clog2(NBITS)+3  latched m_size.
REQ-020 eng_y  in  NBITS  engine result, eng_a*eng_b*R^-1 mod m.
REQ-021 eng_done_irq_p  in  1  engine completion pulse.

Function
REQ-022 enable_p in IDLE shall latch mode, a, b, e, m, m_size and r_red; enable_p while busy is ignored.
REQ-023 States: IDLE, CONV_A, CONV_B, ONE, MUL, SQR, EMUL, FROM.
- Each non-IDLE state has two phases: ISSUE, then WAIT.
REQ-024 ISSUE: eng_enable_p high for exactly one cycle, with eng_a/eng_b driven in that cycle.
- eng_a/eng_b held stable until the matching eng_done_irq_p.
REQ-025 WAIT: on eng_done_irq_p, capture eng_y and transition; the next ISSUE occurs in the following cycle.
REQ-026 eng_done_irq_p in IDLE, or in an ISSUE cycle, shall be ignored.
REQ-027 MUL sequence:
- CONV_A(a, r_red) -> aM
- CONV_B(b, r_red) -> bM
- MUL(aM, bM) -> acc
- FROM(acc, 1) -> y
- 4 engine ops total.
REQ-028 EXP sequence: CONV_A -> aM, then ONE(r_red, 1) -> acc (R mod m).
REQ-029 EXP exponent loop, bit index i = EBITS-1 down to 0:
- SQR(acc, acc) -> acc.
- If e[i] = 1: EMUL(acc, aM) -> acc.
- If e[i] = 0 and CONST_TIME = 1: EMUL is issued and its result discarded.
REQ-030 EXP shall finish with FROM(acc, 1) -> y.
REQ-031 EXP engine op count: 3 + EBITS + popcount(e), or 3 + 2*EBITS when CONST_TIME = 1.
REQ-032 First eng_enable_p shall occur exactly 1 cycle after the accepted enable_p.
REQ-033 On FROM completion: y updated and done_irq_p high 1 cycle after the final eng_done_irq_p.
- busy deasserts in the following cycle.
- y holds until the next completion.
REQ-034 e = 0 in EXP shall yield y = 1 mod m; no exponent-loop skipping is permitted.
REQ-035 The block shall perform no modular arithmetic itself: only operand muxing, bit counting and sequencing.

Reset
REQ-036 rst_n low at any time forces IDLE, with these values:
- y = 0, done_irq_p = 0, busy = 0, eng_enable_p = 0
- eng_a = eng_b = eng_m = eng_m_size = 0
- loop counter = 0
REQ-037 After a mid-operation reset, a late eng_done_irq_p is ignored and no done_irq_p is produced.

Verification
Bench uses a behavioural engine with 3-cycle latency, NBITS = 16, EBITS = 4, m = 13, m_size = 4, r_red = 9.
REQ-038 MUL, a = 5, b = 7 -> y = 9.
- Exactly 4 eng_enable_p pulses.
- done_irq_p 1 cycle after the 4th eng_done_irq_p.
REQ-039 EXP, a = 2, e = 10 -> y = 10 with 9 engine ops.
- Same run with CONST_TIME = 1 -> y = 10 with 11 engine ops.
REQ-040 EXP, a = 6, e = 0 -> y = 1 with 7 engine ops.
REQ-041 enable_p re-pulsed mid-EXP with different operands -> ignored; the first result completes unchanged.
REQ-042 rst_n low during SQR WAIT, then an eng_done_irq_p -> all outputs 0, no done_irq_p.
- A new MUL afterwards completes with y = 9.
